// File: rtl/hazard_pkg.sv
// Shared constants for the register hazard scoreboard.
// Consumer-stage codes, producer latencies, counter width.
package hazard_pkg;

  localparam int USE_ID  = 0;
  localparam int USE_EX  = 1;
  localparam int USE_MEM = 2;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  // Smallest width able to hold 0..max_lat.
  function automatic int cnt_width(input int max_lat);
    int w;
    w = 1;
    while ((1 << w) < (max_lat + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: cycles left until a register is forwardable.
// Clear beats load, and load beats the free-running decrement.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: flush, newest writer, or one step closer to ready.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard driving PC/IF-ID stall and ID/EX bubble.
// Optional perf counters: define HAZARD_SB_PERF_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS = 32,
  parameter  int REG_AW   = 5,
  parameter  int MAX_LAT  = 15,
  parameter  int USE_W    = 2,
  localparam int CW       = cnt_width(MAX_LAT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [USE_W-1:0]  id_use_stage,
  input  logic              id_reg_write,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [CW-1:0]     id_lat,
  input  logic              sb_clear,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic [1:0]        hazard_src,
  output logic [CW-1:0]     busy_cnt,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_hazard_events
);

  logic [CW-1:0] cnt [NUM_REGS];
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rt;
  logic [CW-1:0] lat_c;
  logic          conf_a;
  logic          conf_b;
  logic          stall;
  logic          fire;

  assign cnt[0] = '0;

  if (MAX_LAT < (2**CW) - 1) begin : g_clamp
    localparam logic [CW-1:0] MAX_C = CW'(MAX_LAT);
    assign lat_c = (id_lat > MAX_C) ? MAX_C : id_lat;
  end else begin : g_noclamp
    assign lat_c = id_lat;
  end

  // Look up source counts against pre-update state.
  always_comb begin
    cnt_rs = '0;
    cnt_rt = '0;
    if (int'(id_rs) < NUM_REGS) cnt_rs = cnt[id_rs];
    if (int'(id_rt) < NUM_REGS) cnt_rt = cnt[id_rt];
  end

  // A source conflicts while its producer is later than its consumer.
  always_comb begin
    conf_a = id_valid & id_rs_used & (id_rs != '0)
           & (int'(cnt_rs) > int'(id_use_stage));
    conf_b = id_valid & id_rt_used & (id_rt != '0)
           & (int'(cnt_rt) > int'(id_use_stage));
    stall  = conf_a | conf_b;
    fire   = id_valid & ~stall;
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    logic ld;
    assign ld = fire & id_reg_write & (id_dst == REG_AW'(r));
    hazard_sb_entry #(.CW(CW)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (sb_clear),
      .load     (ld),
      .load_val (lat_c),
      .cnt      (cnt[r])
    );
  end

  assign pc_stall     = stall;
  assign if_id_stall  = stall;
  assign id_ex_bubble = stall;
  assign hazard_src   = {conf_b, conf_a};
  assign busy_cnt     = cnt_rs;

`ifdef HAZARD_SB_PERF_EN
  logic        stall_q;
  logic        stall_d;
  logic [31:0] stall_cyc_q;
  logic [31:0] stall_cyc_d;
  logic [31:0] haz_evt_q;
  logic [31:0] haz_evt_d;

  // Saturating stall-cycle and stall-onset counters.
  always_comb begin
    stall_d     = stall;
    stall_cyc_d = stall_cyc_q;
    haz_evt_d   = haz_evt_q;
    if (sb_clear) begin
      stall_cyc_d = '0;
      haz_evt_d   = '0;
    end else begin
      if (stall && stall_cyc_q != '1)
        stall_cyc_d = stall_cyc_q + 1'b1;
      if (stall && !stall_q && haz_evt_q != '1)
        haz_evt_d = haz_evt_q + 1'b1;
    end
  end

  // Perf state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      stall_cyc_q <= '0;
      haz_evt_q   <= '0;
    end else begin
      stall_q     <= stall_d;
      stall_cyc_q <= stall_cyc_d;
      haz_evt_q   <= haz_evt_d;
    end
  end

  assign perf_stall_cycles  = stall_cyc_q;
  assign perf_hazard_events = haz_evt_q;
`else
  assign perf_stall_cycles  = '0;
  assign perf_hazard_events = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Honours HAZARD_SB_PERF_EN for the perf expectations.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic [1:0]  id_use_stage;
  logic        id_reg_write;
  logic [4:0]  id_dst;
  logic [3:0]  id_lat;
  logic        sb_clear;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_bubble;
  logic [1:0]  hazard_src;
  logic [3:0]  busy_cnt;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_hazard_events;

  int checks = 0;
  int errors = 0;
  int n;

  hazard_scoreboard dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .id_valid           (id_valid),
    .id_rs              (id_rs),
    .id_rt              (id_rt),
    .id_rs_used         (id_rs_used),
    .id_rt_used         (id_rt_used),
    .id_use_stage       (id_use_stage),
    .id_reg_write       (id_reg_write),
    .id_dst             (id_dst),
    .id_lat             (id_lat),
    .sb_clear           (sb_clear),
    .pc_stall           (pc_stall),
    .if_id_stall        (if_id_stall),
    .id_ex_bubble       (id_ex_bubble),
    .hazard_src         (hazard_src),
    .busy_cnt           (busy_cnt),
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_hazard_events (perf_hazard_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_valid     = 1'b0;
    id_rs        = '0;
    id_rt        = '0;
    id_rs_used   = 1'b0;
    id_rt_used   = 1'b0;
    id_use_stage = '0;
    id_reg_write = 1'b0;
    id_dst       = '0;
    id_lat       = '0;
  endtask

  task automatic issue(input int dst, input int lat);
    idle();
    id_valid     = 1'b1;
    id_reg_write = 1'b1;
    id_dst       = 5'(dst);
    id_lat       = 4'(lat);
  endtask

  task automatic src(input int rs, input int rsu,
                     input int rt, input int rtu,
                     input int use_stg);
    idle();
    id_valid     = 1'b1;
    id_rs        = 5'(rs);
    id_rs_used   = 1'(rsu);
    id_rt        = 5'(rt);
    id_rt_used   = 1'(rtu);
    id_use_stage = 2'(use_stg);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (16) next();
  endtask

  task automatic count_stall(output int cnt);
    cnt = 0;
    for (int i = 0; i < 20 && pc_stall; i++) begin
      cnt++;
      next();
    end
  endtask

  initial begin
    idle();
    sb_clear = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(pc_stall), 0);
    chk("rst_src", 32'(hazard_src), 0);
    chk("rst_busy", 32'(busy_cnt), 0);
    chk("rst_pst", perf_stall_cycles, 0);
    #2 rst_n = 1'b1;

    // ALU -> branch
    next(); issue(8, LAT_ALU); #1;
    chk("alu_issue_nostall", 32'(pc_stall), 0);
    next(); src(8, 1, 0, 0, USE_ID); #1;
    chk("alu_br_stall", 32'(pc_stall), 1);
    chk("alu_br_src", 32'(hazard_src), 32'h1);
    chk("alu_br_bubble", 32'(id_ex_bubble), 1);
    next();
    chk("alu_br_fire", 32'(if_id_stall), 0);

    // load -> ALU via rt
    drain();
    next(); issue(9, LAT_LOAD); #1;
    next(); src(0, 0, 9, 1, USE_EX); #1;
    chk("ld_alu_stall", 32'(pc_stall), 1);
    chk("ld_alu_src", 32'(hazard_src), 32'h2);
    next();
    chk("ld_alu_fire", 32'(pc_stall), 0);

    // long op
    drain();
    next(); issue(5, 6); #1;
    next(); src(5, 1, 0, 0, USE_EX); #1;
    count_stall(n);
    chk("long_len", n, 5);
    chk("long_busy_end", 32'(busy_cnt), 1);

    // unused operand
    drain();
    next(); issue(5, 6); #1;
    next(); src(5, 0, 0, 0, USE_EX); #1;
    chk("unused_stall", 32'(pc_stall), 0);
    chk("unused_busy", 32'(busy_cnt), 6);

    // register 0
    next(); issue(0, 6); #1;
    next(); src(0, 1, 0, 1, USE_ID); #1;
    chk("r0_stall", 32'(pc_stall), 0);
    chk("r0_busy", 32'(busy_cnt), 0);

    // WAW
    drain();
    next(); issue(3, 6); #1;
    next(); issue(3, 1); #1;
    chk("waw_second_fires", 32'(pc_stall), 0);
    next(); src(3, 1, 0, 0, USE_ID); #1;
    chk("waw_busy", 32'(busy_cnt), 1);
    chk("waw_stall", 32'(pc_stall), 1);
    next();
    chk("waw_release", 32'(pc_stall), 0);

    // clear discards a same-cycle issue
    drain();
    next(); issue(7, 4); #1;
    next(); issue(7, 9); id_rs = 5'd7; sb_clear = 1'b1; #1;
    chk("clr_busy_before", 32'(busy_cnt), 4);
    next(); sb_clear = 1'b0; src(7, 1, 0, 0, USE_ID); #1;
    chk("clr_busy_after", 32'(busy_cnt), 0);
    chk("clr_no_stall", 32'(pc_stall), 0);

    // clear drops a live stall
    next(); issue(7, 4); #1;
    next(); src(7, 1, 0, 0, USE_ID); #1;
    chk("clr2_stall", 32'(pc_stall), 1);
    sb_clear = 1'b1; #1;
    chk("clr2_sync", 32'(pc_stall), 1);
    next(); sb_clear = 1'b0; #1;
    chk("clr2_drop", 32'(pc_stall), 0);

    // async reset mid-stall
    drain();
    next(); issue(10, 8); #1;
    next(); src(10, 1, 10, 1, USE_ID); #1;
    chk("rst2_stall", 32'(pc_stall), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst2_pc", 32'(pc_stall), 0);
    chk("rst2_ifid", 32'(if_id_stall), 0);
    chk("rst2_bub", 32'(id_ex_bubble), 0);
    chk("rst2_src", 32'(hazard_src), 0);
    chk("rst2_busy", 32'(busy_cnt), 0);
    chk("rst2_pst", perf_stall_cycles, 0);
    #1 rst_n = 1'b1;
    next();
    chk("rst2_after", 32'(hazard_src), 0);

    // perf: stalls of 3 and 2 cycles
    drain();
    next(); issue(11, 3); #1;
    next(); src(11, 1, 0, 0, USE_ID); #1;
    count_stall(n);
    chk("perf_len1", n, 3);
    next(); issue(12, 3); #1;
    next(); src(0, 0, 12, 1, USE_EX); #1;
    count_stall(n);
    chk("perf_len2", n, 2);
    next(); idle();
    next();
`ifdef HAZARD_SB_PERF_EN
    chk("perf_cycles", perf_stall_cycles, 5);
    chk("perf_events", perf_hazard_events, 2);
    sb_clear = 1'b1;
    next(); sb_clear = 1'b0;
    chk("perf_clr", perf_stall_cycles, 0);
`else
    chk("perf_cycles", perf_stall_cycles, 0);
    chk("perf_events", perf_hazard_events, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's split load-use and branch-use hazard detectors.
- A per-register countdown scoreboard records how many cycles remain until each in-flight destination value becomes forwardable.
- Compares the ID-stage instruction's sources against the scoreboard, using a generic consumer stage, and drives PC stall, IF/ID stall and an ID/EX bubble.
- Supports arbitrary producer latencies (load, multiply, divide) instead of fixed ALU/load cases.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired and never tracked.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NUM_REGS.
- MAX_LAT, 15, largest producer latency; counter width CW = $clog2(MAX_LAT+1).
- USE_W, 2, width of the consumer-stage code (0 = ID, 1 = EX, 2 = MEM, ...).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  source A index.
- id_rt  in  REG_AW  source B index.
- id_rs_used  in  1  source A is actually read.
- id_rt_used  in  1  source B is actually read.
- id_use_stage  in  USE_W  earliest stage that consumes the sources.
- id_reg_write  in  1  instruction writes a register.
- id_dst  in  REG_AW  destination index.
- id_lat  in  CW  cycles after leaving ID until the result can be forwarded to an ID-stage consumer.
- sb_clear  in  1  synchronous clear of all entries (exception/flush of all in-flight writers).
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- id_ex_bubble  out  1  inject a NOP into ID/EX.
- hazard_src  out  2  bit0 = source A conflict, bit1 = source B conflict.
- busy_cnt  out  CW  current count for id_rs (debug).
- perf_stall_cycles  out  32  see Optional Feature.
- perf_hazard_events  out  32  see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, all outputs 0.
- State: one counter cnt[r] per register r in 1..NUM_REGS-1; cnt[0] reads as 0 and ignores writes.
- Hazard detection, combinational from registered state and ID inputs:
  - conflict A = id_valid & id_rs_used & (id_rs != 0) & (cnt[id_rs] > id_use_stage).
  - conflict B is the same, using id_rt.
  - stall = A | B.
  - pc_stall = if_id_stall = id_ex_bubble = stall.
  - hazard_src = {B, A}.
- Issue: fire = id_valid & ~stall.
- Per-cycle update, in priority order:
  1. If sb_clear, every cnt becomes 0. A same-cycle issue is discarded.
  2. Otherwise every nonzero cnt decrements by 1.
  3. Then, if fire & id_reg_write & (id_dst != 0), cnt[id_dst] is loaded with min(id_lat, MAX_LAT). This overrides the decrement of that entry (write-after-write: the newest writer wins).
- id_lat = 0 creates no entry.
- Source check uses pre-update state, so an instruction whose dst equals its own src compares against the older writer.
- Stall is not registered: the same cycle a counter decrements to <= id_use_stage, stall drops.
- Stalls last at most MAX_LAT cycles for any single hazard. No deadlock is possible because counters always decrement while stalled.
- Equivalences with the current pipeline:
  - ALU producer: id_lat = 1.
  - Load producer: id_lat = 2.
  - Branch consumer: use_stage 0.
  - ALU consumer: use_stage 1.
- Reset asserted mid-stall clears immediately; the first cycle after release has no hazard.

Optional Feature:
- Macro HAZARD_SB_PERF_EN.
- When defined:
  - perf_stall_cycles increments on every cycle with stall = 1.
  - perf_hazard_events increments on each rising edge of stall (stall now 1, previous cycle 0).
  - Both counters saturate at 2**32-1, reset to 0 via rst_n and also clear on sb_clear.
- When undefined: both outputs tie to constant 0 and no counter logic is generated.

Decomposition:
- Package hazard_pkg holds:
  - use-stage constants USE_ID = 0, USE_EX = 1, USE_MEM = 2;
  - latency constants LAT_ALU = 1, LAT_LOAD = 2;
  - a function clog2-based counter-width helper.
- One sub-module, hazard_sb_entry: a single register's counter with inputs clear, load, load_val and output cnt, instantiated in a generate loop for r = 1..NUM_REGS-1.

Test Plan:
- ALU-to-branch: issue dst = 8, lat = 1; next instruction rs = 8, use_stage = 0 → stall 1 cycle, hazard_src = 01, then fire.
- Load-to-ALU: issue dst = 9, lat = 2; next instruction rt = 9, use_stage = 1 → stall exactly 1 cycle, hazard_src = 10.
- Long op plus unused operand: dst = 5, lat = 6, followed by rs = 5, use_stage = 1 → 5 stall cycles. Repeating with id_rs_used = 0 → 0 stalls. Register 0 as a source → never stalls.
- WAW: issue dst = 3, lat = 6, then dst = 3, lat = 1 → cnt[3] = 1 after the second issue, and a reader of 3 at use_stage 0 stalls only 1 cycle.
- Clear and reset: sb_clear while cnt[7] = 4 and a new issue to 7 → cnt[7] = 0 and stall drops next cycle. rst_n pulsed low mid-stall → all outputs 0 asynchronously.
- Perf (HAZARD_SB_PERF_EN defined): two separate stalls of 3 and 2 cycles → perf_stall_cycles = 5, perf_hazard_events = 2. With the macro undefined, both read 0.
